sram_audio_ctrl: RTL and testbench
==================================

Name: sram_audio_ctrl

Overview:
- Sequencer and owner of the 256Kx16 SRAM for the audio recorder.
- Records codec ADC samples into SRAM, then plays them back to the DAC path at normal, fast (skip) or slow (repeat or linear-interpolate) speed, with pause/stop.
- Sits between the I2S receive/transmit blocks and the SRAM pins.
- Mode control comes from debounced key/switch logic.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, sample width (signed two's complement)
MAX_ADDR, 2**18-1, last usable SRAM address

Ports:
CLK50  in  1  system clock, 50 MHz
RESET  in  1  synchronous, active-high reset
start_rec  in  1  one-cycle pulse: begin recording at address 0
start_play  in  1  one-cycle pulse: begin playback at address 0
pause_tgl  in  1  one-cycle pulse: toggle pause
stop  in  1  one-cycle pulse: end current operation
fast  in  1  1 = fast (skip) playback, 0 = slow (repeat) playback
interp  in  1  slow mode only: 1 = linear interpolation, 0 = sample repeat
speed  in  2  ratio N = 1<<speed (1,2,4,8); speed=0 is normal speed
adc_valid  in  1  pulse: adc_sample valid
adc_sample  in  16  recorded sample
dac_req  in  1  pulse: DAC needs the next sample
dac_sample  out  16  playback sample
dac_valid  out  1  pulse: dac_sample valid
state  out  3  IDLE=0, REC=1, REC_PAUSE=2, PRIME=3, PLAY=4, PLAY_PAUSE=5
end_addr  out  18  one past the last recorded address
overrun  out  1  sticky: adc_valid dropped while busy
SRAM_ADDR  out  18  SRAM address
SRAM_DQ_O  out  16  write data
SRAM_DQ_OE  out  1  drive SRAM_DATA when 1
SRAM_DQ_I  in  16  read data
SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes

Behaviour:
- Reset:
  - state=IDLE; end_addr=0; overrun=0.
  - dac_sample=0, dac_valid=0.
  - SRAM_ADDR=0, SRAM_DQ_OE=0, WE_N=1, OE_N=1.
  - CE_N/UB_N/LB_N=0 (held 0 always).
  - Internal wr_addr, rd_addr, phase k, cur, nxt = 0.
  - A reset mid-access aborts the access; strobes return to reset values on the next edge.
- Command priority (same cycle): stop > start_rec > start_play > pause_tgl.
  - Commands are accepted in any state.
  - A start command aborts the current operation.
- Write access (3 cycles):
  - c0: ADDR=wr_addr, DQ_O=sample, DQ_OE=1.
  - c1: WE_N=0.
  - c2: WE_N=1, then DQ_OE=0.
- Read access (3 cycles):
  - c0: ADDR, OE_N=0.
  - c2: capture SRAM_DQ_I, then OE_N=1.
  - Only one access in flight at a time.
- REC:
  - adc_valid with engine idle: write the sample, then wr_addr+1.
  - adc_valid with engine busy: sample dropped, overrun=1.
  - Write to MAX_ADDR completes: end_addr=MAX_ADDR+1 (saturate at 2**18, internally 19 bits), go to IDLE.
  - stop: end_addr=wr_addr, go to IDLE.
  - pause_tgl: REC<->REC_PAUSE; adc_valid is ignored in REC_PAUSE.
- start_play:
  - If end_addr=0, stay IDLE.
  - Otherwise: rd_addr=0, k=0, enter PRIME.
  - PRIME reads cur=mem[rd_addr], then nxt=mem[rd_addr+1] (nxt=cur if rd_addr+1>=end_addr), then goes to PLAY.
- dac_req handling:
  - Answered exactly 1 cycle later with dac_valid=1 in every state.
  - Output is 0 unless the state is PLAY.
  - In PLAY the output is computed from cur/nxt before advancing:
    - normal or fast, or slow with interp=0: out=cur.
    - slow with interp=1: out=cur+(((nxt-cur)*k)>>>speed). Use a 17-bit signed diff and arithmetic shift; the result fits in 16 bits.
- Advance after each PLAY dac_req:
  - speed=0: rd_addr+=1.
  - fast: rd_addr+=N.
  - slow: k+=1; if k==N, then k=0 and rd_addr+=1.
  - If rd_addr changed: refetch cur/nxt (two reads, ≤6 cycles).
  - If the new rd_addr>=end_addr: go to IDLE, no refetch.
- dac_req spacing of ≥8 cycles is guaranteed by the DAC block. A dac_req arriving during a refetch outputs from the stale cur/nxt.
- PLAY/PRIME + pause_tgl: go to PLAY_PAUSE, pointers frozen. pause_tgl again returns to PLAY.
- stop during PLAY/PRIME/PLAY_PAUSE: go to IDLE.
- Mode inputs (fast/interp/speed) are sampled at each advance. A speed change resets k to 0.

Test Plan:
- Record 5 samples (100,200,300,400,500), then stop -> end_addr=5; SRAM holds them at addresses 0..4; WE_N low exactly 1 cycle per write.
- Play at speed=0 with 5 dac_req -> dac_sample 100,200,300,400,500, each 1 cycle after dac_req; then state=IDLE; further dac_req returns 0.
- fast=1, speed=1 on the same data -> 100,300,500, then IDLE.
- Slow, interp=1, speed=2, data 100,200 -> 100,125,150,175,200,200,...; with interp=0 -> 100,100,100,100,200.
- pause_tgl during PLAY, 3 dac_req, pause_tgl -> three 0 outputs; playback resumes at the same sample. Also: stop and start_rec in the same cycle -> IDLE.
- adc_valid pulses 1 cycle apart -> second sample dropped, overrun=1. Also: RESET asserted mid-write -> WE_N=1 and DQ_OE=0 next cycle, state=IDLE.

Source files
------------

// File: rtl/sram_audio_ctrl_if.sv
// SRAM pin bundle between the audio sequencer (master) and the 256Kx16 SRAM (slave).
// Latency: none, wires only.
// Backpressure: none; the SRAM answers every access within the fixed 3-cycle window.
interface sram_audio_ctrl_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_DQ_O;
  logic [DATA_W-1:0] SRAM_DQ_I;
  logic              SRAM_DQ_OE;
  logic              SRAM_WE_N;
  logic              SRAM_OE_N;
  logic              SRAM_CE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;

  modport master (
    output SRAM_ADDR, SRAM_DQ_O, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N,
    output SRAM_CE_N, SRAM_UB_N, SRAM_LB_N,
    input  SRAM_DQ_I
  );

  modport slave (
    input  SRAM_ADDR, SRAM_DQ_O, SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N,
    input  SRAM_CE_N, SRAM_UB_N, SRAM_LB_N,
    output SRAM_DQ_I
  );
endinterface

// File: rtl/sram_audio_ctrl.sv
// Audio record/playback sequencer owning the SRAM; one 3-cycle SRAM access in flight at a time.
// Latency: dac_req answered 1 cycle later; write/read 3 cycles each; cur/nxt refetch <= 6 cycles.
// Backpressure: none; ADC samples arriving while the SRAM engine is busy are dropped (sticky overrun).
module sram_audio_ctrl #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int MAX_ADDR = 2**18-1
) (
  input  logic              CLK50,
  input  logic              RESET,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              pause_tgl,
  input  logic              stop,
  input  logic              fast,
  input  logic              interp,
  input  logic [1:0]        speed,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_sample,
  input  logic              dac_req,
  output logic [DATA_W-1:0] dac_sample,
  output logic              dac_valid,
  output logic [2:0]        state,
  output logic [ADDR_W-1:0] end_addr,
  output logic              overrun,
  sram_audio_ctrl_if.master sram
);

  // Pointers carry one extra bit so "one past MAX_ADDR" and fast-mode overshoot are representable.
  localparam int PW = ADDR_W + 1;
  localparam int MW = DATA_W + 5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PRIME      = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

  state_t st, st_nx;

  logic [PW-1:0]            wr_addr, rd_addr, end_q;
  logic [2:0]               k;
  logic [1:0]               spd_q;
  logic signed [DATA_W-1:0] cur, nxt;

  // SRAM access engine: busy/cyc walk c0..c2; tag selects cur (0) or nxt (1) for a read.
  logic        busy, is_wr, discard, tag, last_wr, fetch_pend;
  logic [1:0]  cyc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_o_q;
  logic        dq_oe_q, we_n_q, oe_n_q;

  logic              cmd_abort, cmd_any;
  logic              rd_done, wr_done, has_nxt, fetch_fin;
  logic [PW-1:0]     rec_end, rd_plus1, adv_addr;
  logic [2:0]        k_eff, k_nx;
  logic [3:0]        n_ratio;
  logic              adv_go, adv_end, refetch;
  logic signed [DATA_W:0] diff;
  logic signed [MW-1:0]   prod;
  logic [DATA_W-1:0] play_out;

  assign sram.SRAM_ADDR  = addr_q;
  assign sram.SRAM_DQ_O  = dq_o_q;
  assign sram.SRAM_DQ_OE = dq_oe_q;
  assign sram.SRAM_WE_N  = we_n_q;
  assign sram.SRAM_OE_N  = oe_n_q;
  assign sram.SRAM_CE_N  = 1'b0;
  assign sram.SRAM_UB_N  = 1'b0;
  assign sram.SRAM_LB_N  = 1'b0;
  assign state           = st;
  // A completely full SRAM (2**18) shows as 0 on the 18-bit port; internally it is kept exact.
  assign end_addr        = end_q[ADDR_W-1:0];

  // Playback arithmetic, advance step and access-completion decode.
  always_comb begin
    cmd_abort = stop | start_rec | start_play;
    cmd_any   = cmd_abort | pause_tgl;
    rd_done   = busy && (cyc == 2'd2) && !is_wr && !discard;
    wr_done   = busy && (cyc == 2'd2) && is_wr;
    rd_plus1  = rd_addr + PW'(1);
    has_nxt   = rd_plus1 < end_q;
    fetch_fin = rd_done && (tag || !has_nxt);
    // start_play out of a recording uses the length recorded so far
    rec_end   = (st == S_REC || st == S_REC_PAUSE) ? wr_addr : end_q;
    n_ratio   = 4'd1 << speed;
    // a speed change restarts the interpolation phase
    k_eff     = (speed != spd_q) ? 3'd0 : k;

    diff = {nxt[DATA_W-1], nxt} - {cur[DATA_W-1], cur};
    prod = MW'(diff) * MW'($signed({1'b0, k_eff}));
    if (!fast && interp && speed != 2'd0) play_out = cur + DATA_W'(prod >>> speed);
    else                                  play_out = cur;

    adv_addr = rd_addr;
    k_nx     = k_eff;
    if (speed == 2'd0) begin
      adv_addr = rd_plus1;
      k_nx     = 3'd0;
    end else if (fast) begin
      adv_addr = rd_addr + PW'(n_ratio);
      k_nx     = 3'd0;
    end else if (({1'b0, k_eff} + 4'd1) == n_ratio) begin
      adv_addr = rd_plus1;
      k_nx     = 3'd0;
    end else begin
      k_nx = k_eff + 3'd1;
    end
    adv_go  = (st == S_PLAY) && dac_req && !cmd_any;
    adv_end = adv_addr >= end_q;
    refetch = adv_go && !adv_end && (adv_addr != rd_addr);
  end

  // Next state: commands first (stop > start_rec > start_play > pause), then internal events.
  always_comb begin
    st_nx = st;
    if (stop) begin
      st_nx = S_IDLE;
    end else if (start_rec) begin
      st_nx = S_REC;
    end else if (start_play) begin
      st_nx = (rec_end == '0) ? S_IDLE : S_PRIME;
    end else if (pause_tgl) begin
      case (st)
        S_REC:             st_nx = S_REC_PAUSE;
        S_REC_PAUSE:       st_nx = S_REC;
        S_PRIME, S_PLAY:   st_nx = S_PLAY_PAUSE;
        S_PLAY_PAUSE:      st_nx = S_PLAY;
        default:           st_nx = st;
      endcase
    end else begin
      case (st)
        S_REC, S_REC_PAUSE: if (wr_done && last_wr) st_nx = S_IDLE;
        S_PRIME:            if (fetch_fin) st_nx = S_PLAY;
        S_PLAY:             if (adv_go && adv_end) st_nx = S_IDLE;
        default:            st_nx = st;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK50) begin
    if (RESET) st <= S_IDLE;
    else       st <= st_nx;
  end

  // Datapath: DAC response, SRAM engine, recording, playback pointers and command side effects.
  always_ff @(posedge CLK50) begin
    if (RESET) begin
      dac_sample <= '0;
      dac_valid  <= 1'b0;
      overrun    <= 1'b0;
      end_q      <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      k          <= '0;
      spd_q      <= '0;
      cur        <= '0;
      nxt        <= '0;
      busy       <= 1'b0;
      cyc        <= '0;
      is_wr      <= 1'b0;
      discard    <= 1'b0;
      tag        <= 1'b0;
      last_wr    <= 1'b0;
      fetch_pend <= 1'b0;
      addr_q     <= '0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
    end else begin
      dac_valid <= dac_req;
      if (dac_req) dac_sample <= (st == S_PLAY) ? play_out : '0;

      // engine sequencing; WE_N is low only during c1, data held through c2
      if (busy) begin
        cyc <= cyc + 2'd1;
        if (cyc == 2'd0) begin
          we_n_q <= !is_wr;
        end else if (cyc == 2'd1) begin
          we_n_q <= 1'b1;
        end else begin
          busy    <= 1'b0;
          cyc     <= 2'd0;
          dq_oe_q <= 1'b0;
          oe_n_q  <= 1'b1;
        end
      end

      // read capture; a cur read chains straight into the nxt read
      if (rd_done) begin
        if (tag) begin
          nxt <= sram.SRAM_DQ_I;
        end else begin
          cur <= sram.SRAM_DQ_I;
          if (has_nxt) begin
            busy   <= 1'b1;
            cyc    <= 2'd0;
            oe_n_q <= 1'b0;
            tag    <= 1'b1;
            addr_q <= rd_plus1[ADDR_W-1:0];
          end else begin
            nxt <= sram.SRAM_DQ_I;
          end
        end
      end

      // deferred cur/nxt fetch once the engine is free
      if (fetch_pend && !busy && !cmd_abort) begin
        busy       <= 1'b1;
        cyc        <= 2'd0;
        is_wr      <= 1'b0;
        discard    <= 1'b0;
        tag        <= 1'b0;
        oe_n_q     <= 1'b0;
        addr_q     <= rd_addr[ADDR_W-1:0];
        fetch_pend <= 1'b0;
      end

      // recording: accept into an idle engine, otherwise drop and flag
      if (st == S_REC && adc_valid && !cmd_abort) begin
        if (busy) begin
          overrun <= 1'b1;
        end else begin
          busy    <= 1'b1;
          cyc     <= 2'd0;
          is_wr   <= 1'b1;
          discard <= 1'b0;
          addr_q  <= wr_addr[ADDR_W-1:0];
          dq_o_q  <= adc_sample;
          dq_oe_q <= 1'b1;
          wr_addr <= wr_addr + PW'(1);
          last_wr <= (wr_addr == PW'(MAX_ADDR));
        end
      end

      // memory full: the write to MAX_ADDR has landed
      if (wr_done && last_wr && (st == S_REC || st == S_REC_PAUSE) && !cmd_abort) begin
        end_q   <= PW'(MAX_ADDR) + PW'(1);
        last_wr <= 1'b0;
      end

      // playback advance; a read still in flight is stale and gets replaced
      if (adv_go) begin
        rd_addr <= adv_addr;
        k       <= k_nx;
        spd_q   <= speed;
        if (refetch) begin
          if (busy) begin
            discard    <= 1'b1;
            fetch_pend <= 1'b1;
          end else begin
            busy    <= 1'b1;
            cyc     <= 2'd0;
            is_wr   <= 1'b0;
            discard <= 1'b0;
            tag     <= 1'b0;
            oe_n_q  <= 1'b0;
            addr_q  <= adv_addr[ADDR_W-1:0];
          end
        end
      end

      // start/stop: any read in flight belongs to the abandoned operation; writes still finish
      if (cmd_abort) begin
        discard    <= 1'b1;
        fetch_pend <= 1'b0;
        last_wr    <= 1'b0;
        if ((st == S_REC || st == S_REC_PAUSE) && (stop || !start_rec)) end_q <= wr_addr;
        if (!stop && start_rec) begin
          wr_addr <= '0;
        end else if (!stop && start_play && rec_end != '0) begin
          rd_addr    <= '0;
          k          <= '0;
          spd_q      <= speed;
          fetch_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_audio_ctrl.sv
// Self-checking bench for sram_audio_ctrl with a behavioural SRAM and playback reference model.
// Latency: expects dac_valid exactly one cycle after each dac_req.
// Backpressure: dac_req spaced 10 cycles apart; ADC samples spaced 6 cycles apart except in the overrun test.
module tb_sram_audio_ctrl;

  logic        CLK50;
  logic        RESET;
  logic        start_rec, start_play, pause_tgl, stop, fast, interp;
  logic [1:0]  speed;
  logic        adc_valid;
  logic [15:0] adc_sample;
  logic        dac_req;
  logic [15:0] dac_sample;
  logic        dac_valid;
  logic [2:0]  state;
  logic [17:0] end_addr;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  sram_audio_ctrl_if #(.ADDR_W(18), .DATA_W(16)) sif ();

  sram_audio_ctrl dut (
    .CLK50(CLK50), .RESET(RESET),
    .start_rec(start_rec), .start_play(start_play), .pause_tgl(pause_tgl), .stop(stop),
    .fast(fast), .interp(interp), .speed(speed),
    .adc_valid(adc_valid), .adc_sample(adc_sample),
    .dac_req(dac_req), .dac_sample(dac_sample), .dac_valid(dac_valid),
    .state(state), .end_addr(end_addr), .overrun(overrun),
    .sram(sif)
  );

  initial begin
    CLK50 = 1'b0;
    forever #10 CLK50 = ~CLK50;
  end

  // behavioural SRAM: write on a clock edge while WE_N is low, asynchronous read while OE_N is low
  logic [15:0] mem [0:262143];
  always @(posedge CLK50)
    if (!sif.SRAM_WE_N && sif.SRAM_DQ_OE && !sif.SRAM_CE_N) mem[sif.SRAM_ADDR] <= sif.SRAM_DQ_O;
  assign sif.SRAM_DQ_I = !sif.SRAM_OE_N ? mem[sif.SRAM_ADDR] : 16'hDEAD;

  // write-strobe activity counters
  int   we_low = 0, we_runs = 0, we_bad = 0;
  logic we_prev = 1'b1;
  always @(negedge CLK50) begin
    if (!sif.SRAM_WE_N) begin
      we_low++;
      if (we_prev) we_runs++;
      if (!sif.SRAM_DQ_OE) we_bad++;
    end
    we_prev = sif.SRAM_WE_N;
  end

  logic signed [15:0] smp[$];
  int                 exp_q[$];

  task automatic tick();
    @(posedge CLK50);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cmd(input bit r, input bit p, input bit pt, input bit s);
    start_rec = r; start_play = p; pause_tgl = pt; stop = s;
    tick();
    start_rec = 0; start_play = 0; pause_tgl = 0; stop = 0;
  endtask

  task automatic rec_one(input logic [15:0] v);
    adc_sample = v;
    adc_valid  = 1'b1;
    tick();
    adc_valid = 1'b0;
    ticks(5);
  endtask

  task automatic record_smp();
    cmd(1, 0, 0, 0);
    foreach (smp[i]) rec_one(smp[i]);
    cmd(0, 0, 0, 1);
  endtask

  task automatic do_req(output logic [15:0] s, output logic v1, output logic v0);
    dac_req = 1'b1;
    tick();
    s  = dac_sample;
    v1 = dac_valid;
    dac_req = 1'b0;
    tick();
    v0 = dac_valid;
    ticks(8);
  endtask

  task automatic wait_play(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (state == 3'd4) ok = 1;
      else tick();
    end
  endtask

  // expected playback stream derived from the recorded samples and mode
  function automatic void build_model(input bit f, input bit ip, input int sp);
    int n = 1 << sp;
    int len = smp.size();
    exp_q.delete();
    if (sp == 0) begin
      for (int i = 0; i < len; i++) exp_q.push_back(int'(smp[i]));
    end else if (f) begin
      for (int i = 0; i < len; i += n) exp_q.push_back(int'(smp[i]));
    end else begin
      for (int i = 0; i < len; i++) begin
        int c = smp[i];
        int x = (i + 1 < len) ? int'(smp[i+1]) : c;
        for (int kk = 0; kk < n; kk++) begin
          int d = (x - c) * kk;
          int q = d / n;
          if (d % n != 0 && d < 0) q = q - 1;
          exp_q.push_back(ip ? c + q : c);
        end
      end
    end
  endfunction

  task automatic test_reset();
    RESET = 1; start_rec = 0; start_play = 0; pause_tgl = 0; stop = 0;
    fast = 0; interp = 0; speed = 0; adc_valid = 0; adc_sample = 0; dac_req = 0;
    ticks(3);
    checks++; if (state !== 3'd0)      begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (end_addr !== 18'd0)  begin errors++; $display("FAIL reset_end_addr got=%0d exp=0", end_addr); end
    checks++; if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (dac_valid !== 1'b0 || dac_sample !== 16'd0)
      begin errors++; $display("FAIL reset_dac got=%b/%h exp=0/0000", dac_valid, dac_sample); end
    checks++; if (sif.SRAM_ADDR !== 18'd0 || sif.SRAM_DQ_OE !== 1'b0)
      begin errors++; $display("FAIL reset_addr_oe got=%h/%b exp=0/0", sif.SRAM_ADDR, sif.SRAM_DQ_OE); end
    checks++; if (sif.SRAM_WE_N !== 1'b1 || sif.SRAM_OE_N !== 1'b1)
      begin errors++; $display("FAIL reset_strobes got=%b%b exp=11", sif.SRAM_WE_N, sif.SRAM_OE_N); end
    checks++; if ({sif.SRAM_CE_N, sif.SRAM_UB_N, sif.SRAM_LB_N} !== 3'b000)
      begin errors++; $display("FAIL reset_ce_ub_lb got=%b exp=000", {sif.SRAM_CE_N, sif.SRAM_UB_N, sif.SRAM_LB_N}); end
    RESET = 0;
    tick();
  endtask

  task automatic test_record();
    int l0 = we_low, r0 = we_runs, b0 = we_bad;
    smp = '{16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd500};
    record_smp();
    checks++; if (end_addr !== 18'd5) begin errors++; $display("FAIL rec_end_addr got=%0d exp=5", end_addr); end
    checks++; if (state !== 3'd0)     begin errors++; $display("FAIL rec_state got=%0d exp=0", state); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL rec_overrun got=%b exp=0", overrun); end
    foreach (smp[i]) begin
      checks++;
      if (mem[i] !== smp[i]) begin errors++; $display("FAIL rec_mem addr=%0d got=%h exp=%h", i, mem[i], smp[i]); end
    end
    checks++;
    if (we_low - l0 !== 5 || we_runs - r0 !== 5 || we_bad - b0 !== 0) begin
      errors++;
      $display("FAIL rec_we_pulses low=%0d runs=%0d undriven=%0d exp=5/5/0", we_low - l0, we_runs - r0, we_bad - b0);
    end
  endtask

  task automatic test_playback(input string nm, input bit f, input bit ip, input int sp);
    bit ok;
    logic [15:0] s;
    logic v1, v0;
    fast = f; interp = ip; speed = 2'(sp);
    build_model(f, ip, sp);
    cmd(0, 1, 0, 0);
    wait_play(ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_prime state=%0d exp=4", nm, state); end
    foreach (exp_q[i]) begin
      logic [15:0] e = 16'(exp_q[i]);
      do_req(s, v1, v0);
      checks++;
      if (s !== e || v1 !== 1'b1 || v0 !== 1'b0) begin
        errors++;
        $display("FAIL %s_sample idx=%0d got=%h valid=%b,%b exp=%h valid=1,0", nm, i, s, v1, v0, e);
      end
    end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL %s_end_state got=%0d exp=0", nm, state); end
    do_req(s, v1, v0);
    checks++;
    if (s !== 16'd0 || v1 !== 1'b1) begin errors++; $display("FAIL %s_idle_req got=%h/%b exp=0000/1", nm, s, v1); end
  endtask

  task automatic test_slow();
    smp = '{16'sd100, 16'sd200};
    record_smp();
    test_playback("slow_interp", 0, 1, 2);
    test_playback("slow_repeat", 0, 0, 2);
  endtask

  task automatic test_pause();
    bit ok;
    logic [15:0] s;
    logic v1, v0;
    smp = '{16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd500};
    record_smp();
    fast = 0; interp = 0; speed = 0;
    cmd(0, 1, 0, 0);
    wait_play(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pause_prime state=%0d exp=4", state); end
    do_req(s, v1, v0);
    checks++; if (s !== 16'd100) begin errors++; $display("FAIL pause_first got=%h exp=0064", s); end
    cmd(0, 0, 1, 0);
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL pause_state got=%0d exp=5", state); end
    for (int i = 0; i < 3; i++) begin
      do_req(s, v1, v0);
      checks++;
      if (s !== 16'd0 || v1 !== 1'b1) begin errors++; $display("FAIL pause_zero idx=%0d got=%h/%b exp=0000/1", i, s, v1); end
    end
    cmd(0, 0, 1, 0);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL resume_state got=%0d exp=4", state); end
    do_req(s, v1, v0);
    checks++; if (s !== 16'd200) begin errors++; $display("FAIL resume_sample got=%h exp=00c8", s); end
    cmd(0, 0, 0, 1);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL play_stop got=%0d exp=0", state); end
    cmd(1, 0, 0, 1);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL stop_beats_rec got=%0d exp=0", state); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len = $urandom_range(2, 9);
      smp.delete();
      for (int i = 0; i < len; i++) smp.push_back(16'($urandom));
      record_smp();
      checks++;
      if (end_addr !== 18'(len)) begin errors++; $display("FAIL rand_end_addr it=%0d got=%0d exp=%0d", it, end_addr, len); end
      test_playback("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_overrun();
    cmd(1, 0, 0, 0);
    adc_valid = 1; adc_sample = 16'h1234;
    tick();
    adc_sample = 16'h5678;
    tick();
    adc_valid = 0;
    ticks(5);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    cmd(0, 0, 0, 1);
    checks++; if (end_addr !== 18'd1) begin errors++; $display("FAIL overrun_end_addr got=%0d exp=1", end_addr); end
    checks++; if (mem[0] !== 16'h1234) begin errors++; $display("FAIL overrun_mem got=%h exp=1234", mem[0]); end
  endtask

  task automatic test_reset_midwrite();
    cmd(1, 0, 0, 0);
    adc_valid = 1; adc_sample = 16'hBEEF;
    tick();
    adc_valid = 0;
    tick();
    checks++; if (sif.SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL midwrite_we_low got=%b exp=0", sif.SRAM_WE_N); end
    RESET = 1;
    tick();
    checks++;
    if (sif.SRAM_WE_N !== 1'b1 || sif.SRAM_DQ_OE !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL midwrite_reset got we_n=%b oe=%b state=%0d exp=1/0/0", sif.SRAM_WE_N, sif.SRAM_DQ_OE, state);
    end
    checks++; if (overrun !== 1'b0 || end_addr !== 18'd0) begin errors++; $display("FAIL midwrite_regs got=%b/%0d exp=0/0", overrun, end_addr); end
    RESET = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_record();
    test_playback("normal", 0, 0, 0);
    test_playback("fast", 1, 0, 1);
    test_slow();
    test_pause();
    test_random();
    test_overrun();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
